// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequence controller.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INPUT    = 3'd1,
    PLAYBACK = 3'd2,
    REPEAT   = 3'd3,
    FAIL     = 3'd4,
    WIN      = 3'd5
  } state_e;

  localparam logic [3:0] LEDS_OFF   = 4'b0000;
  localparam logic [3:0] LEDS_FAIL  = 4'b1111;
  localparam logic [3:0] LEDS_WIN_A = 4'b1010;
  localparam logic [3:0] LEDS_WIN_B = 4'b0101;

endpackage

// File: rtl/simon_seq_ctrl_if.sv
// Player/LED bus between the board front end and the Simon sequence controller.
interface simon_seq_ctrl_if #(parameter int DEPTH = 16);
  logic                   start;
  logic                   enter;
  logic [3:0]             pattern;
  logic                   legal;
  logic                   tick;
  logic [3:0]             leds;
  logic [2:0]             state_o;
  logic [$clog2(DEPTH):0] seq_len;
  logic                   illegal;

  modport master (output start, enter, pattern, legal, tick,
                  input  leds, state_o, seq_len, illegal);
  modport slave  (input  start, enter, pattern, legal, tick,
                  output leds, state_o, seq_len, illegal);
endinterface

// File: rtl/simon_seq_mem.sv
// DEPTH x 4 pattern store: one synchronous write port, one asynchronous read port, no reset.
module simon_seq_mem #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [3:0]    rdata_o
);

  logic [DEPTH-1:0][3:0] mem_q;

  // write one pattern slot; contents survive reset, len tracks validity
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon sequence controller: records legal patterns, plays them back and
// checks the second player's repetition.
// Optional build macro SIMON_TIMEOUT_EN adds a per-entry tick timeout in REPEAT.
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  simon_seq_ctrl_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    leds_q, leds_d;
  logic          illegal_q, illegal_d;
  logic          we;
  logic [3:0]    rd_data;
  logic          last;

`ifdef SIMON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // write address is the next free slot; the read port always follows idx,
  // which serves both playback display and repeat comparison
  simon_seq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (len_q[IW-1:0]),
    .wdata_i (bus.pattern),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

  assign last = ({1'b0, idx_q} == (len_q - LW'(1)));

  // next-state, counters and LED selection
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    illegal_d = 1'b0;
    we        = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    if (bus.start) begin
      state_d = INPUT;
      len_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        INPUT: if (bus.enter) begin
          if (bus.legal) begin
            we      = 1'b1;
            len_d   = len_q + LW'(1);
            idx_d   = '0;
            state_d = PLAYBACK;
          end else begin
            illegal_d = 1'b1;
          end
        end
        PLAYBACK: if (bus.tick) begin
          if (last) begin
            idx_d   = '0;
            state_d = REPEAT;
`ifdef SIMON_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        REPEAT: begin
          if (bus.enter) begin
            if (bus.pattern == rd_data) begin
`ifdef SIMON_TIMEOUT_EN
              tmo_d = '0;
`endif
              if (last) state_d = (len_q == LW'(DEPTH)) ? WIN : INPUT;
              else      idx_d   = idx_q + IW'(1);
            end else begin
              state_d = FAIL;
            end
          end
`ifdef SIMON_TIMEOUT_EN
          else if (bus.tick) begin
            if (int'(tmo_q) + 1 >= TIMEOUT_TICKS) state_d = FAIL;
            else                                  tmo_d   = tmo_q + TW'(1);
          end
`endif
        end
        default: ;
      endcase
    end

    case (state_d)
      INPUT, REPEAT: leds_d = bus.pattern;
      FAIL:          leds_d = LEDS_FAIL;
      // WIN_A and WIN_B are bitwise complements, so a tick just inverts
      WIN:           leds_d = (state_q != WIN) ? LEDS_WIN_A : (bus.tick ? ~leds_q : leds_q);
      default:       leds_d = LEDS_OFF;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      leds_q    <= LEDS_OFF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      leds_q    <= leds_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef SIMON_TIMEOUT_EN
  // ticks elapsed since REPEAT entry or the last accepted entry
  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  // playback shows the stored slot straight from the register file
  assign bus.leds    = (state_q == PLAYBACK) ? rd_data : leds_q;
  assign bus.state_o = state_q;
  assign bus.seq_len = len_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Self-checking bench for simon_seq_ctrl: directed scenarios with literal
// expectations plus randomized play against a queue-based game model.
// Honours SIMON_TIMEOUT_EN when defined.
module tb_simon_seq_ctrl;
  localparam int DEPTH = 4;
  localparam int TO    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simon_seq_ctrl_if #(.DEPTH(DEPTH)) bus();
  simon_seq_ctrl #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  // game model: the stored sequence is a queue, its size is the length
  int         m_st = 0, m_idx = 0, m_tmo = 0, m_len = 0;
  logic [3:0] m_leds = 4'h0;
  logic       m_ill = 1'b0;
  logic [3:0] m_seq[$];

  always @(posedge clk) begin
    int st, ix, tm;
    logic [3:0] ld;
    logic il;
    st = m_st; ix = m_idx; tm = m_tmo; ld = m_leds; il = 1'b0;
    if (!rst_n) begin
      st = 0; ix = 0; tm = 0; m_seq.delete();
    end else if (bus.start) begin
      st = 1; ix = 0; m_seq.delete();
    end else if (st == 1 && bus.enter) begin
      if (bus.legal) begin m_seq.push_back(bus.pattern); ix = 0; st = 2; end
      else il = 1'b1;
    end else if (st == 2 && bus.tick) begin
      if (ix == m_seq.size() - 1) begin ix = 0; st = 3; tm = 0; end
      else ix++;
    end else if (st == 3) begin
      if (bus.enter) begin
        if (bus.pattern != m_seq[ix]) st = 4;
        else begin
          tm = 0;
          if (ix == m_seq.size() - 1) st = (m_seq.size() == DEPTH) ? 5 : 1;
          else ix++;
        end
      end
`ifdef SIMON_TIMEOUT_EN
      else if (bus.tick) begin
        tm++;
        if (tm == TO) st = 4;
      end
`endif
    end
    case (st)
      1, 3:    ld = bus.pattern;
      2:       ld = m_seq[ix];
      4:       ld = 4'hF;
      5:       ld = (m_st != 5) ? 4'hA : (bus.tick ? ~m_leds : m_leds);
      default: ld = 4'h0;
    endcase
    m_st   <= st;
    m_idx  <= ix;
    m_tmo  <= tm;
    m_leds <= ld;
    m_ill  <= il;
    m_len  <= m_seq.size();
  end

  // every cycle: DUT outputs against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_state",   int'(bus.state_o), m_st);
      chk("model_len",     int'(bus.seq_len), m_len);
      chk("model_leds",    int'(bus.leds),    int'(m_leds));
      chk("model_illegal", int'(bus.illegal), int'(m_ill));
    end
  end

  task automatic cyc(input bit s, input bit e, input logic [3:0] p, input bit l, input bit t);
    bus.start = s; bus.enter = e; bus.pattern = p; bus.legal = l; bus.tick = t;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 0, 0);
  endtask

  logic [3:0] list[$];

  initial begin
    bus.start = 0; bus.enter = 0; bus.pattern = 0; bus.legal = 0; bus.tick = 0;
    chk_en = 1'b1;
    idle(); idle();
    chk("rst_state", int'(bus.state_o), 0);
    chk("rst_len",   int'(bus.seq_len), 0);
    chk("rst_leds",  int'(bus.leds),    0);
    rst_n = 1'b1;
    idle();

    // illegal entry is rejected with a one-cycle pulse
    cyc(1, 0, 4'h0, 0, 0);
    chk("start_state", int'(bus.state_o), 1);
    cyc(0, 1, 4'b0011, 0, 0);
    chk("illegal_pulse", int'(bus.illegal), 1);
    chk("illegal_state", int'(bus.state_o), 1);
    chk("illegal_len",   int'(bus.seq_len), 0);
    idle();
    chk("illegal_clear", int'(bus.illegal), 0);

    // two-round game: 0001 then 0100
    cyc(0, 1, 4'b0001, 1, 0);
    chk("acc1_state", int'(bus.state_o), 2);
    chk("acc1_leds",  int'(bus.leds),    1);
    cyc(0, 0, 4'h0, 0, 1);
    chk("pb1_to_rep", int'(bus.state_o), 3);
    cyc(0, 1, 4'b0001, 0, 0);
    chk("rep1_done",  int'(bus.state_o), 1);
    cyc(0, 1, 4'b0100, 1, 0);
    chk("pb2_first",  int'(bus.leds),    1);
    cyc(0, 0, 4'h0, 0, 1);
    chk("pb2_second", int'(bus.leds),    4);
    cyc(0, 0, 4'h0, 0, 1);
    chk("pb2_to_rep", int'(bus.state_o), 3);
    cyc(0, 1, 4'b0001, 0, 0);
    cyc(0, 1, 4'b0100, 0, 0);
    chk("rep2_state", int'(bus.state_o), 1);
    chk("rep2_len",   int'(bus.seq_len), 2);

    // reset mid-playback with len=3
    cyc(0, 1, 4'b1001, 1, 0);
    chk("pb3_len", int'(bus.seq_len), 3);
    rst_n = 1'b0;
    idle();
    chk("midrst_state",   int'(bus.state_o), 0);
    chk("midrst_len",     int'(bus.seq_len), 0);
    chk("midrst_leds",    int'(bus.leds),    0);
    chk("midrst_illegal", int'(bus.illegal), 0);
    rst_n = 1'b1;

    // mismatch ends in FAIL; start restarts
    cyc(1, 0, 4'h0, 0, 0);
    cyc(0, 1, 4'b0010, 1, 0);
    cyc(0, 0, 4'h0, 0, 1);
    cyc(0, 1, 4'b1000, 1, 0);
    chk("fail_state", int'(bus.state_o), 4);
    chk("fail_leds",  int'(bus.leds),    15);
    cyc(1, 0, 4'h0, 0, 0);
    chk("fail_restart_state", int'(bus.state_o), 1);
    chk("fail_restart_len",   int'(bus.seq_len), 0);

    // full game to WIN
    list.delete();
    for (int r = 0; r < DEPTH; r++) begin
      list.push_back(4'($urandom));
      cyc(0, 1, list[r], 1, 0);
      for (int k = 0; k < list.size(); k++) cyc(0, 0, 4'h0, 0, 1);
      for (int k = 0; k < list.size(); k++) cyc(0, 1, list[k], 0, 0);
    end
    chk("win_state", int'(bus.state_o), 5);
    chk("win_leds_a", int'(bus.leds), 4'b1010);
    chk("win_len", int'(bus.seq_len), DEPTH);
    cyc(0, 0, 4'h0, 0, 1);
    chk("win_leds_b", int'(bus.leds), 4'b0101);
    idle();
    chk("win_hold", int'(bus.leds), 4'b0101);
    cyc(1, 1, 4'h7, 1, 0);
    chk("start_enter_state", int'(bus.state_o), 1);
    chk("start_enter_len",   int'(bus.seq_len), 0);

    // REPEAT waiting on ticks
    cyc(0, 1, 4'h6, 1, 0);
    cyc(0, 0, 4'h0, 0, 1);
    cyc(0, 0, 4'h0, 0, 1);
    cyc(0, 0, 4'h0, 0, 1);
    chk("tmo_two_ticks", int'(bus.state_o), 3);
    cyc(0, 0, 4'h0, 0, 1);
`ifdef SIMON_TIMEOUT_EN
    chk("tmo_expire", int'(bus.state_o), 4);
`else
    chk("no_tmo_wait", int'(bus.state_o), 3);
`endif
    cyc(1, 0, 4'h0, 0, 0);
    cyc(0, 1, 4'h6, 1, 0);
    cyc(0, 0, 4'h0, 0, 1);
    cyc(0, 0, 4'h0, 0, 1);
    cyc(0, 0, 4'h0, 0, 1);
    cyc(0, 1, 4'h6, 0, 1);
    chk("tick_enter_accept", int'(bus.state_o), 1);

    // randomized play; the player usually answers correctly in REPEAT
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] p;
      p = 4'($urandom);
      if (m_st == 3 && m_idx < m_seq.size() && ($urandom % 5) != 0) p = m_seq[m_idx];
      rst_n = (($urandom % 400) != 0);
      cyc(($urandom % 80) == 0, ($urandom % 4) == 0, p, ($urandom % 4) != 0, ($urandom % 3) == 0);
    end
    rst_n = 1'b1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
